// File: rtl/arith_seq_pkg.sv
// Shared op codes and FSM state encoding for arith_seq_unit.
package arith_seq_pkg;

    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_INCB  = 3'b001;
    localparam logic [2:0] OP_ADD2  = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_NEGB  = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/arith_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from per-bit full-adder equations.
module arith_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[CHUNK];

endmodule

// File: rtl/arith_seq_unit.sv
// Multi-cycle arithmetic unit: CHUNK bits per clock with valid/ready handshakes.
// Define ARITH_SEQ_SAT_EN to clamp overflowing results to the signed extreme.
module arith_seq_unit
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] x_r, y_r, acc_r, result_r;
    logic             carry_r, x_msb_r, y_msb_r;
    logic [CW-1:0]    cnt_r;
    logic             in_ready_r, out_valid_r;
    logic             flag_c_r, flag_z_r, flag_n_r, flag_v_r;

    logic [WIDTH-1:0] x_eff_s, y_eff_s, acc_nx_s, final_s;
    logic             cin_eff_s, ovf_s, last_s;
    logic [CHUNK-1:0] sum_s;
    logic             cout_s;

    // Map the op code onto effective adder operands.
    always_comb begin
        x_eff_s   = {WIDTH{1'b0}};
        y_eff_s   = {WIDTH{1'b0}};
        cin_eff_s = 1'b0;
        case (op)
            OP_PASSA: x_eff_s = op_a;
            OP_INCB: begin
                y_eff_s   = op_b;
                cin_eff_s = 1'b1;
            end
            OP_ADD2: begin
                x_eff_s = op_a;
                y_eff_s = WIDTH'(2'b10);
            end
            OP_ADD: begin
                x_eff_s = op_a;
                y_eff_s = op_b;
            end
            OP_NEGB: begin
                y_eff_s   = ~op_b;
                cin_eff_s = 1'b1;
            end
            OP_SUB: begin
                x_eff_s   = op_a;
                y_eff_s   = ~op_b;
                cin_eff_s = 1'b1;
            end
            default: begin
                x_eff_s   = {WIDTH{1'b0}};
                y_eff_s   = {WIDTH{1'b0}};
                cin_eff_s = 1'b0;
            end
        endcase
    end

    // Operands shift right so the active chunk always sits in the low bits.
    arith_chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .a    (x_r[CHUNK-1:0]),
        .b    (y_r[CHUNK-1:0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    assign last_s = (cnt_r == LAST_CNT);

    // Accumulate sum chunks from the top; after NCHUNK steps chunk 0 lands at the LSB.
    always_comb begin
        acc_nx_s                  = acc_r >> CHUNK;
        acc_nx_s[WIDTH-1 -: CHUNK] = sum_s;
        ovf_s = (x_msb_r == y_msb_r) && (acc_nx_s[WIDTH-1] != x_msb_r);
`ifdef ARITH_SEQ_SAT_EN
        if (ovf_s) begin
            final_s = x_msb_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_s = acc_nx_s;
        end
`else
        final_s = acc_nx_s;
`endif
    end

    // Next-state logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            x_msb_r     <= 1'b0;
            y_msb_r     <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            flag_c_r    <= 1'b0;
            flag_z_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            flag_v_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r     <= x_eff_s;
                        y_r     <= y_eff_s;
                        carry_r <= cin_eff_s;
                        x_msb_r <= x_eff_s[WIDTH-1];
                        y_msb_r <= y_eff_s[WIDTH-1];
                        acc_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    x_r     <= x_r >> CHUNK;
                    y_r     <= y_r >> CHUNK;
                    carry_r <= cout_s;
                    acc_r   <= acc_nx_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        result_r <= final_s;
                        flag_c_r <= cout_s;
                        flag_z_r <= (final_s == {WIDTH{1'b0}});
                        flag_n_r <= final_s[WIDTH-1];
                        flag_v_r <= ovf_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flag_c    = flag_c_r;
    assign flag_z    = flag_z_r;
    assign flag_n    = flag_n_r;
    assign flag_v    = flag_v_r;

endmodule

// File: doc/arith_seq_unit.md
Name: arith_seq_unit

Overview:
Parametrised, multi-cycle successor to the 8-bit switch-selected arithmetic circuit. It keeps the same six-operation encoding, but widens to WIDTH bits and computes the result CHUNK bits per clock through a ripple-carry chunk adder. It adds valid/ready handshakes on input and output, and reports carry, zero, negative and overflow flags. It sits between operand sources (ROM/registers) and result consumers (LED driver, display logic).

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥2 and a multiple of CHUNK.
- CHUNK, 2: bits processed per RUN cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous, active-low reset.
- in_valid, input, 1: operands and op are valid.
- in_ready, output, 1: unit can accept a command.
- op, input, 3: operation select.
- op_a, input, WIDTH: operand A.
- op_b, input, WIDTH: operand B.
- out_valid, output, 1: result and flags valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, WIDTH: computed value.
- flag_c, output, 1: carry out of the MSB.
- flag_z, output, 1: result == 0.
- flag_n, output, 1: result[WIDTH-1].
- flag_v, output, 1: signed overflow.

Behaviour:
- Effective adder inputs (x, y, cin) per op:
  - 000: A, 0, 0 (pass A)
  - 001: 0, B, 1 (B+1)
  - 010: A, 2, 0 (A+2)
  - 011: A, B, 0 (A+B)
  - 100: 0, ~B, 1 (−B)
  - 101: A, ~B, 1 (A−B)
  - 110/111: 0, 0, 0 (result 0)
- All arithmetic is modulo 2^WIDTH. flag_c is the raw adder carry, so for subtraction 1 means no borrow.
- flag_v = (x[MSB]==y[MSB]) && (sum[MSB]!=x[MSB]), using the effective x and y.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch x, y and cin; clear the chunk counter; go to RUN.
  - RUN: each cycle, add chunk[cnt] of x and y with the stored carry. Write the sum chunk into the result shift/accumulate register and store the chunk carry. After chunk NCHUNK−1, compute flags and go to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. Minimum issue interval is NCHUNK+2 cycles. in_ready=0 in RUN and DONE.
- Ops 110/111 take the same latency as the others; no early exit.
- in_valid while busy is ignored: not latched, no error.
- op/op_a/op_b changing during RUN have no effect; operands are latched at accept.
- Reset (rst_n=0 on an edge), including mid-RUN or mid-DONE:
  - state goes to IDLE, in_ready=1, out_valid=0;
  - result=0 and all flags=0;
  - the in-flight operation is discarded.
- flag_z and flag_n are derived from the final (possibly saturated) result.

Optional Feature:
- Macro ARITH_SEQ_SAT_EN.
- Defined: when flag_v=1, result is clamped to the signed extreme, for every op.
  - Clamp value is {0,1…1} if x[MSB]=0, else {1,0…0}.
  - flag_v still reports 1; flag_c is unchanged.
- Undefined: result is the wrapped sum; no clamp logic is synthesised.

Decomposition:
- Package arith_seq_pkg holds:
  - op localparams OP_PASSA, OP_INCB, OP_ADD2, OP_ADD, OP_NEGB, OP_SUB (3'b000–3'b101);
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE.
- One sub-module, arith_chunk_adder: a CHUNK-bit ripple-carry adder with sum, cout, a, b, cin, built from generated per-bit full-adder equations. It is instantiated once; the top level handles chunk selection and counter control.

Test Plan:
- All tests use WIDTH=8, CHUNK=2.
- ADD overflow: op=011, A=0x7F, B=0x01.
  - Expect out_valid exactly 4 cycles after accept; result=0x80, c=0, z=0, n=1, v=1.
  - With ARITH_SEQ_SAT_EN: result=0x7F, n=0, v=1.
- SUB with borrow: op=101, A=0x05, B=0x07 → result=0xFE, c=0, n=1, v=0, z=0.
- Wrap and negate:
  - op=001, B=0xFF → 0x00, c=1, z=1.
  - op=100, B=0x00 → 0x00, c=1, z=1.
  - op=100, B=0x80 → 0x80, v=1 (0x7F with SAT).
- Backpressure: complete op=010, A=0x10 (→0x12). Hold out_ready=0 for 5 cycles.
  - result and flags stay 0x12 and unchanged; in_ready stays 0.
  - A second in_valid pulse during this window is ignored.
  - On out_ready=1, go to IDLE on the next edge.
- Reset mid-op: accept op=011, A=0x33, B=0x44; drive rst_n=0 for 1 cycle after 2 RUN cycles.
  - Expect out_valid=0, result=0, in_ready=1.
  - A following op=000, A=0xA5 yields 0xA5, n=1, with no residue from the aborted op.
